// File: rtl/pipe_regs_pkg.sv
// Shared pipeline register types: decoded control word, forwarding record and
// the issue-slot state used by the decode-to-execute register.
package pipe_regs;

  typedef struct packed {
    logic [4:0] rd;
    logic       rf_wr_en;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       rs1_used;
    logic       rs2_used;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } data_fwd_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    VALID  = 2'd1,
    BUBBLE = 2'd2
  } issue_state_e;

  // A killed slot must not write the register file or touch memory.
  function automatic ctrl_t ctrl_kill(input ctrl_t c);
    ctrl_t k;
    k           = c;
    k.rf_wr_en  = 1'b0;
    k.mem_read  = 1'b0;
    k.mem_write = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/id_ex_issue_reg_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/id_ex_issue_reg.sv
// Decode-to-execute issue register with load-use bubble, EX back-pressure hold
// and flush. Performance counters are built only with ISSUE_PERF_CNT_EN.
//
// state  | meaning
// EMPTY  | slot holds no instruction
// VALID  | slot holds an instruction waiting for / being consumed by EX
// BUBBLE | slot empty because a load-use bubble was inserted last edge
module id_ex_issue_reg
  import pipe_regs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  ctrl_t           id_ctrl_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            rs1_lu_hazard_i,
  input  logic            rs2_lu_hazard_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output ctrl_t           ex_ctrl_o,
  output logic [XLEN-1:0] ex_rs1_o,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     bubble_cnt_o,
`endif
  output logic [XLEN-1:0] ex_rs2_o
);

  issue_state_e    r_state, w_state_nxt;
  logic            w_hazard, w_advance, w_capture, w_kill, w_bubble;
  logic [XLEN-1:0] r_pc, r_rs1, r_rs2;
  ctrl_t           r_ctrl;

  assign w_hazard   = id_valid_i & (rs1_lu_hazard_i | rs2_lu_hazard_i);
  assign w_advance  = (r_state != VALID) | ex_ready_i;
  assign id_ready_o = w_advance & ~w_hazard & ~flush_i;

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_kill      = 1'b0;
    w_bubble    = 1'b0;
    if (flush_i) begin
      w_state_nxt = EMPTY;
      w_kill      = 1'b1;
    end else if (!w_advance) begin
      w_state_nxt = r_state;
    end else if (w_hazard) begin
      w_state_nxt = BUBBLE;
      w_kill      = 1'b1;
      w_bubble    = 1'b1;
    end else if (id_valid_i) begin
      w_state_nxt = VALID;
      w_capture   = 1'b1;
    end else begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and operands load only on capture, so they stay stable under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc   <= '0;
      r_ctrl <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
    end else if (w_capture) begin
      r_pc   <= id_pc_i;
      r_ctrl <= id_ctrl_i;
      r_rs1  <= rs1_data_i;
      r_rs2  <= rs2_data_i;
    end else if (w_kill) begin
      r_ctrl <= ctrl_kill(r_ctrl);
    end
  end

  assign ex_valid_o = (r_state == VALID);
  assign ex_pc_o    = r_pc;
  assign ex_ctrl_o  = r_ctrl;
  assign ex_rs1_o   = r_rs1;
  assign ex_rs2_o   = r_rs2;

`ifdef ISSUE_PERF_CNT_EN
  logic w_stall;
  assign w_stall = id_valid_i & ~id_ready_o;

  sat_counter #(.W(32)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_stall),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.W(32)) u_bubble_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (w_bubble),
    .cnt_o  (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_id_ex_issue_reg.sv
// Self-checking bench for id_ex_issue_reg: directed vector table, hand-written
// hazard/reset sequences, then randomized traffic against a slot model.
module tb_id_ex_issue_reg;
  import pipe_regs::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            id_valid_i;
  logic            id_ready_o;
  logic [XLEN-1:0] id_pc_i;
  ctrl_t           id_ctrl_i;
  logic [XLEN-1:0] rs1_data_i, rs2_data_i;
  logic            rs1_lu_hazard_i, rs2_lu_hazard_i;
  logic            flush_i, ex_ready_i;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_pc_o;
  ctrl_t           ex_ctrl_o;
  logic [XLEN-1:0] ex_rs1_o, ex_rs2_o;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]     stall_cnt_o, bubble_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  id_ex_issue_reg #(.XLEN(XLEN)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .id_valid_i      (id_valid_i),
    .id_ready_o      (id_ready_o),
    .id_pc_i         (id_pc_i),
    .id_ctrl_i       (id_ctrl_i),
    .rs1_data_i      (rs1_data_i),
    .rs2_data_i      (rs2_data_i),
    .rs1_lu_hazard_i (rs1_lu_hazard_i),
    .rs2_lu_hazard_i (rs2_lu_hazard_i),
    .flush_i         (flush_i),
    .ex_ready_i      (ex_ready_i),
    .ex_valid_o      (ex_valid_o),
    .ex_pc_o         (ex_pc_o),
    .ex_ctrl_o       (ex_ctrl_o),
    .ex_rs1_o        (ex_rs1_o),
`ifdef ISSUE_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o),
`endif
    .ex_rs2_o        (ex_rs2_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] op1_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Drive one decode beat; control always requests a register write.
  task automatic drive(input logic v, input logic [31:0] pc, input logic h1, input logic h2,
                       input logic fl, input logic rdy);
    ctrl_t c;
    c            = '0;
    c.rd         = pc[6:2];
    c.rf_wr_en   = 1'b1;
    c.alu_op     = pc[5:2];
    c.rs1_used   = 1'b1;
    id_valid_i      = v;
    id_pc_i         = pc;
    id_ctrl_i       = c;
    rs1_data_i      = h1 ? 32'hDEAD_BEEF : op1_of(pc);
    rs2_data_i      = ~pc;
    rs1_lu_hazard_i = h1;
    rs2_lu_hazard_i = h2;
    flush_i         = fl;
    ex_ready_i      = rdy;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        h1, h2, fl, rdy;
    logic        e_idrdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_wr;
  } vec_t;

  vec_t vecs[15];

  // Behavioural slot model for the random phase.
  logic        m_valid;
  logic [31:0] m_pc, m_rs1, m_rs2;
  ctrl_t       m_ctrl;
  int          m_stall, m_bubble;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        haz, adv, exp_rdy;
    logic [CTRL_W-1:0] cbits;

    vecs[0]  = '{1'b1, 32'h010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h010, 1'b1};
    vecs[1]  = '{1'b1, 32'h014, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h014, 1'b1};
    vecs[2]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h014, 1'b0};
    vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1};
    vecs[4]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
    vecs[5]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1};
    vecs[6]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1};
    vecs[7]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1};
    vecs[8]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1};
    vecs[9]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h204, 1'b1};
    vecs[10] = '{1'b1, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0};
    vecs[11] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, 1'b0};
    vecs[12] = '{1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h204, 1'b0};
    vecs[13] = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1};
    vecs[14] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1};

    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 64'(ex_valid_o), 64'd0);
    chk("rst_pc",    64'(ex_pc_o),    64'd0);
    chk("rst_ctrl",  64'(ex_ctrl_o),  64'd0);
    chk("rst_rs1",   64'(ex_rs1_o),   64'd0);
    chk("rst_rs2",   64'(ex_rs2_o),   64'd0);
`ifdef ISSUE_PERF_CNT_EN
    chk("rst_stall",  64'(stall_cnt_o),  64'd0);
    chk("rst_bubble", 64'(bubble_cnt_o), 64'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].h1, vecs[i].h2, vecs[i].fl, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_id_ready", i), 64'(id_ready_o), 64'(vecs[i].e_idrdy));
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(ex_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_pc", i),    64'(ex_pc_o),    64'(vecs[i].e_pc));
      chk($sformatf("vec%0d_wr", i),    64'(ex_ctrl_o.rf_wr_en), 64'(vecs[i].e_wr));
      chk($sformatf("vec%0d_rs1", i),   64'(ex_rs1_o),   64'(op1_of(vecs[i].e_pc)));
    end
`ifdef ISSUE_PERF_CNT_EN
    chk("vec_stall_cnt",  64'(stall_cnt_o),  64'd7);
    chk("vec_bubble_cnt", 64'(bubble_cnt_o), 64'd1);
`endif

    // Hazard held three cycles, then the instruction issues exactly once.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("haz3_id_ready", 64'(id_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("haz3_valid", 64'(ex_valid_o), 64'd0);
    end
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b1);
    rs1_data_i = 32'h4444_4444;
    @(posedge clk_i);
    #1;
    chk("haz3_issue_valid", 64'(ex_valid_o), 64'd1);
    chk("haz3_issue_pc",    64'(ex_pc_o),    64'h400);
    chk("haz3_issue_rs1",   64'(ex_rs1_o),   64'h4444_4444);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    chk("haz3_once", 64'(ex_valid_o), 64'd0);
`ifdef ISSUE_PERF_CNT_EN
    chk("haz3_stall_cnt",  64'(stall_cnt_o),  64'd10);
    chk("haz3_bubble_cnt", 64'(bubble_cnt_o), 64'd4);
`endif

    // Asynchronous reset while EX stalls.
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    chk("arst_pre_valid", 64'(ex_valid_o), 64'd1);
    chk("arst_pre_pc",    64'(ex_pc_o),    64'h500);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid_o), 64'd0);
    chk("arst_pc",    64'(ex_pc_o),    64'd0);
    chk("arst_ctrl",  64'(ex_ctrl_o),  64'd0);
    chk("arst_rs1",   64'(ex_rs1_o),   64'd0);
`ifdef ISSUE_PERF_CNT_EN
    chk("arst_stall",  64'(stall_cnt_o), 64'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_valid  = 1'b0;
    m_pc     = '0;
    m_rs1    = '0;
    m_rs2    = '0;
    m_ctrl   = '0;
    m_stall  = 0;
    m_bubble = 0;
    @(posedge clk_i);
    #1;

    for (int n = 0; n < 2000; n++) begin
      id_valid_i      = ($urandom_range(0, 3) != 0);
      id_pc_i         = $urandom;
      cbits           = CTRL_W'($urandom);
      id_ctrl_i       = cbits;
      rs1_data_i      = $urandom;
      rs2_data_i      = $urandom;
      rs1_lu_hazard_i = ($urandom_range(0, 5) == 0);
      rs2_lu_hazard_i = ($urandom_range(0, 5) == 0);
      flush_i         = ($urandom_range(0, 7) == 0);
      ex_ready_i      = ($urandom_range(0, 3) != 0);
      #1;
      haz     = id_valid_i & (rs1_lu_hazard_i | rs2_lu_hazard_i);
      adv     = !m_valid | ex_ready_i;
      exp_rdy = adv & !haz & !flush_i;
      chk("rnd_id_ready", 64'(id_ready_o), 64'(exp_rdy));
      if (id_valid_i && !exp_rdy) m_stall++;
      if (flush_i || (adv && haz)) begin
        m_valid          = 1'b0;
        m_ctrl.rf_wr_en  = 1'b0;
        m_ctrl.mem_read  = 1'b0;
        m_ctrl.mem_write = 1'b0;
        if (!flush_i) m_bubble++;
      end else if (adv) begin
        m_valid = id_valid_i;
        if (id_valid_i) begin
          m_pc   = id_pc_i;
          m_ctrl = id_ctrl_i;
          m_rs1  = rs1_data_i;
          m_rs2  = rs2_data_i;
        end
      end
      @(posedge clk_i);
      #1;
      chk("rnd_valid", 64'(ex_valid_o), 64'(m_valid));
      chk("rnd_pc",    64'(ex_pc_o),    64'(m_pc));
      chk("rnd_ctrl",  64'(ex_ctrl_o),  64'(m_ctrl));
      chk("rnd_rs1",   64'(ex_rs1_o),   64'(m_rs1));
      chk("rnd_rs2",   64'(ex_rs2_o),   64'(m_rs2));
`ifdef ISSUE_PERF_CNT_EN
      chk("rnd_stall_cnt",  64'(stall_cnt_o),  64'(m_stall));
      chk("rnd_bubble_cnt", 64'(bubble_cnt_o), 64'(m_bubble));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_reg.md
# id_ex_issue_reg

Decode-to-execute issue register. Each cycle it captures the decoded instruction and its two forwarded operands (rs1, rs2) into the EX stage. It inserts a bubble when either operand forwarder reports a load-use hazard, holds its contents while EX back-pressures, and drops its contents on a pipeline flush. It sits between the decode stage (with its two operand forwarders) and the execute stage.

## Interface
Parameters:
- `XLEN`, default 32: operand and PC width.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `id_valid_i`  in  1  decode holds a valid instruction.
- `id_ready_o`  out  1  issue register accepts the decode instruction this cycle.
- `id_pc_i`  in  XLEN  instruction PC.
- `id_ctrl_i`  in  `ctrl_t`  decoded control: rd, rf_wr_en, mem_read, mem_write, alu_op, rs1_used, rs2_used.
- `rs1_data_i`, `rs2_data_i`  in  XLEN  forwarded operand values.
- `rs1_lu_hazard_i`, `rs2_lu_hazard_i`  in  1  load-use hazard flags from the operand forwarders.
- `flush_i`  in  1  branch/jump redirect from EX; kills the younger instruction.
- `ex_ready_i`  in  1  EX consumes the issued instruction this cycle.
- `ex_valid_o`  out  1  issue slot holds a valid instruction.
- `ex_pc_o`  out  XLEN  registered PC.
- `ex_ctrl_o`  out  `ctrl_t`  registered control.
- `ex_rs1_o`, `ex_rs2_o`  out  XLEN  registered operands.
- `stall_cnt_o`, `bubble_cnt_o`  out  32  performance counters. Present only with `ISSUE_PERF_CNT_EN`.

## Operation
- `hazard = id_valid_i & (rs1_lu_hazard_i | rs2_lu_hazard_i)`.
- `advance = !ex_valid_o | ex_ready_i`. The slot is either empty or draining this cycle.
- `id_ready_o = advance & !hazard & !flush_i`. This output is combinational.
- Slot update priority on each rising edge:
  1. `flush_i`: `ex_valid_o` goes to 0, and the rf_wr_en, mem_read and mem_write fields of `ex_ctrl_o` go to 0. This applies even while EX is stalled.
  2. `!advance`: hold every output unchanged.
  3. `hazard`: insert a bubble. `ex_valid_o` goes to 0 and the ctrl write-enable fields are cleared. PC and operands keep their old values.
  4. `id_valid_i`: capture all inputs and set `ex_valid_o` to 1.
  5. Otherwise: `ex_valid_o` goes to 0.
- State is encoded as `issue_state_e` with values EMPTY, VALID, BUBBLE. BUBBLE is EMPTY plus a marker that the previous cycle inserted a bubble for a hazard.
  - A capture moves to VALID.
  - A hazard moves to BUBBLE.
  - A flush or idle cycle moves to EMPTY.
  - VALID holds while `!ex_ready_i`.
- The same instruction can raise a hazard in consecutive cycles, for example while the load waits in EX. One bubble is inserted per such cycle, and the instruction is never lost because `id_ready_o` stays low throughout.
- Payload registers load only on capture. Operands are therefore stable for the whole time `ex_valid_o & !ex_ready_i` holds.

## Timing
- Capture latency is 1 cycle: inputs accepted at edge N appear on the `ex_*` outputs after edge N.
- A load-use hazard costs at least 1 cycle. The dependent instruction issues on the first edge where `hazard` is 0, at which point the forwarder supplies MEM data.
- Flush takes effect at the same edge. No instruction younger than the redirect ever shows `ex_valid_o = 1`.
- Reset values:
  - `ex_valid_o = 0`.
  - `ex_pc_o`, `ex_ctrl_o`, `ex_rs1_o`, `ex_rs2_o` all 0.
  - State EMPTY.
  - Both counters 0.
- Reset asserted mid-stall clears the slot immediately. There is no pending-capture memory.

## Configuration
- `ISSUE_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments every cycle where `id_valid_i & !id_ready_o`, whatever the cause.
  - `bubble_cnt_o` increments on every bubble insertion (priority case 3).
  - Both counters saturate at 0xFFFF_FFFF and never wrap.
- `ISSUE_PERF_CNT_EN` undefined: the counter ports and counter logic do not exist.

## Structure
- The shared `pipe_regs` package holds `ctrl_t` (extended with rs1_used/rs2_used if those fields are not already present) and the new `issue_state_e`. `data_fwd_t` is unchanged.
- One sub-module, `sat_counter` (32-bit saturating up-counter with increment enable), instantiated twice under `ISSUE_PERF_CNT_EN`.

## Test plan
- Back-to-back independent ALU instructions with `ex_ready_i = 1`: each appears on `ex_*` exactly 1 cycle after acceptance, `id_ready_o` stays 1, and `bubble_cnt_o` stays 0.
- `rs1_lu_hazard_i = 1` for one cycle with PC 0x100: `ex_valid_o = 0` for one cycle, then PC 0x100 issues with the MEM-forwarded operand; `bubble_cnt_o = 1`, `stall_cnt_o = 1`.
- Hazard held for 3 cycles: 3 bubbles, `stall_cnt_o = 3`, then the instruction issues exactly once.
- `ex_ready_i = 0` for 4 cycles with PC 0x200 in the slot: all outputs hold and `id_ready_o = 0`; when `ex_ready_i` returns to 1 the next instruction captures on that edge.
- `flush_i` asserted while stalled and while a hazard is active: `ex_valid_o = 0` next cycle and `ex_ctrl_o.rf_wr_en = 0`.
- `rst_ni` asserted asynchronously mid-stall: all outputs go to 0 immediately, without waiting for a clock edge.
